seq_divider: RTL and testbench

//  Iterative radix-2 restoring divider with an integrated FSM, producing one quotient bit per cycle.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 32 +++
 rtl/seq_divider.sv | 179 +++++++++++++++++
 tb/tb_seq_divider.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   state_e   : divider FSM state encoding (IDLE, CALC, FIX, DONE)
//   MAX_WIDTH : widest operand width the divider supports
//   CNT_W     : iteration counter width, sized so it can hold MAX_WIDTH
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int MAX_WIDTH = 64;

    // Sized for the widest legal operand so one counter type serves every WIDTH.
    localparam int CNT_W = $clog2(MAX_WIDTH + 1);

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division step.
//   rem_in   [WIDTH:0]   partial remainder entering the step
//   dvnd_msb             next dividend bit to shift in
//   dvsr     [WIDTH-1:0] divisor magnitude
//   rem_out  [WIDTH:0]   partial remainder leaving the step
//   q_bit                quotient bit produced by the step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvnd_msb,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // The incoming remainder is always below dvsr, so the shifted value is
    // below 2*dvsr < 2^(WIDTH+1); the top bit of diff is then a pure borrow.
    always_comb begin
        shifted = {rem_in, dvnd_msb};
        diff    = shifted - {2'b00, dvsr};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative radix-2 restoring divider, one quotient bit per cycle, with
// optional signed operation and explicit divide-by-zero handling.
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   start        request; operands accepted when start && ready
//   signed_mode  1 = two's-complement operands (honoured only if SIGNED_EN)
//   dividend     dividend, sampled at accept
//   divisor      divisor, sampled at accept
//   ready        high in IDLE
//   busy         high in CALC or FIX
//   out_valid    high in DONE; results stable while high
//   out_ack      consumer acknowledge; DONE -> IDLE
//   quotient     result quotient
//   remainder    result remainder
//   div_by_zero  divisor was zero (qualified by out_valid)
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvnd_q, dvnd_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             divisor_zero;
    logic             sgn_en;
    logic             dvnd_neg;
    logic             dvsr_neg;
    logic [WIDTH-1:0] dvnd_mag;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in   (rem_q),
        .dvnd_msb (dvnd_q[WIDTH-1]),
        .dvsr     (dvsr_q),
        .rem_out  (step_rem),
        .q_bit    (step_q)
    );

    // Operand conditioning at accept. Negating MIN yields MIN, which read as
    // unsigned is exactly 2^(WIDTH-1), so no special case is required.
    always_comb begin
        accept       = start && (state_q == IDLE);
        divisor_zero = (divisor == '0);
        sgn_en       = signed_mode & SIGNED_EN;
        dvnd_neg     = sgn_en & dividend[WIDTH-1];
        dvsr_neg     = sgn_en & divisor[WIDTH-1];
        dvnd_mag     = dvnd_neg ? -dividend : dividend;
        dvsr_mag     = dvsr_neg ? -divisor : divisor;
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvnd_q     <= '0;
            dvsr_q     <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvnd_q     <= dvnd_d;
            dvsr_q     <= dvsr_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = divisor_zero ? DONE : CALC;
            CALC: if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        cnt_d      = cnt_q;
        dvnd_d     = dvnd_q;
        dvsr_d     = dvsr_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d  = CNT_W'(WIDTH);
                    dvnd_d = dvnd_mag;
                    dvsr_d = dvsr_mag;
                    dbz_d  = divisor_zero;
                    if (divisor_zero) begin
                        // Results are final immediately; the raw dividend is returned untouched.
                        quot_d     = '1;
                        rem_d      = {1'b0, dividend};
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                    end else begin
                        quot_d     = '0;
                        rem_d      = '0;
                        neg_quot_d = dvnd_neg ^ dvsr_neg;
                        neg_rem_d  = dvnd_neg;
                    end
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    rem_d  = step_rem;
                    quot_d = {quot_q[WIDTH-2:0], step_q};
                    dvnd_d = {dvnd_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                // Quotient truncates toward zero; remainder takes the dividend's sign.
                quot_d = neg_quot_q ? -quot_q : quot_q;
                rem_d  = {1'b0, (neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0])};
            end
            default: ;
        endcase
    end

    // Outputs decoded from state and result registers.
    always_comb begin
        ready       = (state_q == IDLE);
        busy        = (state_q == CALC) || (state_q == FIX);
        out_valid   = (state_q == DONE);
        quotient    = quot_q;
        remainder   = rem_q[WIDTH-1:0];
        div_by_zero = dbz_q;
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed testbench for seq_divider (WIDTH=32, SIGNED_EN=1).
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W       = 32;
    localparam int LAT     = W + 2;
    localparam int TIMEOUT = 100;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_ack = 1'b0;
    logic         ready;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(
        .WIDTH     (W),
        .SIGNED_EN (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ack     (out_ack),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Presents operands for one cycle, then scrambles them so any late
    // sampling shows up in the result. lat counts edges after the accept edge
    // until out_valid is seen; it saturates at TIMEOUT.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm, output int lat);
        @(negedge clk);
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0001;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int lat, input int exp_lat,
                                 input logic [W-1:0] q, input logic [W-1:0] r,
                                 input logic dbz);
        check({tag, "_lat"}, W'(lat), W'(exp_lat));
        check({tag, "_valid"}, W'(out_valid), W'(1));
        check({tag, "_quot"}, quotient, q);
        check({tag, "_rem"}, remainder, r);
        check({tag, "_dbz"}, W'(div_by_zero), W'(dbz));
    endtask

    initial begin
        int lat;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", W'(ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_quot", quotient, '0);
        check("rst_rem", remainder, '0);
        check("rst_dbz", W'(div_by_zero), W'(0));
        @(negedge clk);
        reset = 1'b1;

        // Unsigned 100/7
        run(32'd100, 32'd7, 1'b0, lat);
        expect_result("u100_7", lat, LAT, 32'd14, 32'd2, 1'b0);
        check("u100_7_ready", W'(ready), W'(0));
        ack();

        // Signed -100/7 and 100/-7
        run(32'hFFFF_FF9C, 32'd7, 1'b1, lat);
        expect_result("s-100_7", lat, LAT, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        ack();
        run(32'd100, 32'hFFFF_FFF9, 1'b1, lat);
        expect_result("s100_-7", lat, LAT, 32'hFFFF_FFF2, 32'd2, 1'b0);
        ack();

        // Divide by zero: valid straight after the accept edge
        run(32'd5, 32'd0, 1'b0, lat);
        expect_result("u5_0", lat, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        ack();
        run(32'd5, 32'd0, 1'b1, lat);
        expect_result("s5_0", lat, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        ack();
        run(32'hFFFF_FFFB, 32'd0, 1'b1, lat);
        expect_result("s-5_0", lat, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        ack();

        // MIN / -1 signed and the same bits unsigned
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        expect_result("s_min_-1", lat, LAT, 32'h8000_0000, 32'd0, 1'b0);
        ack();
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        expect_result("u_min_max", lat, LAT, 32'd0, 32'h8000_0000, 1'b0);
        ack();

        // Unsigned extremes
        run(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        expect_result("u_max_1", lat, LAT, 32'hFFFF_FFFF, 32'd0, 1'b0);
        ack();
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        expect_result("u_max_max", lat, LAT, 32'd1, 32'd0, 1'b0);
        ack();

        // Start during CALC and DONE is ignored; results hold until ack
        @(negedge clk);
        dividend    = 32'd50;
        divisor     = 32'd7;
        signed_mode = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_busy", W'(busy), W'(1));
        check("hold_ready", W'(ready), W'(0));
        @(negedge clk);
        dividend = 32'd1;
        divisor  = 32'd1;
        start    = 1'b1;
        out_ack  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        out_ack = 1'b0;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        expect_result("u50_7", lat + 1, LAT, 32'd7, 32'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dividend = 32'd11;
            divisor  = 32'd2;
            start    = 1'b1;
            @(posedge clk);
            #1;
            check("hold_valid", W'(out_valid), W'(1));
            check("hold_quot", quotient, 32'd7);
            check("hold_rem", remainder, 32'd1);
        end
        // Acknowledge with start also high: that start must not be taken
        @(negedge clk);
        dividend = 32'd77;
        divisor  = 32'd1;
        start    = 1'b1;
        out_ack  = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        out_ack = 1'b0;
        check("ack_ready", W'(ready), W'(1));
        check("ack_valid", W'(out_valid), W'(0));
        @(posedge clk);
        #1;
        check("ack_no_accept", W'(busy), W'(0));
        run(32'd3, 32'd10, 1'b0, lat);
        expect_result("u3_10", lat, LAT, 32'd0, 32'd3, 1'b0);
        ack();

        // Reset mid-operation
        @(negedge clk);
        dividend    = 32'd1000;
        divisor     = 32'd3;
        signed_mode = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ready", W'(ready), W'(1));
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_valid", W'(out_valid), W'(0));
        check("mid_rst_quot", quotient, '0);
        check("mid_rst_rem", remainder, '0);
        check("mid_rst_dbz", W'(div_by_zero), W'(0));
        @(negedge clk);
        reset = 1'b1;
        run(32'd9, 32'd3, 1'b0, lat);
        expect_result("u9_3", lat, LAT, 32'd3, 32'd0, 1'b0);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_divider
